// File: rtl/btn_pkg.sv
// Shared types, default timing constants and helpers for the button event decoder.
package btn_pkg;

  // Decoder FSM states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2,
    LOCKOUT = 2'd3
  } btn_state_t;

  localparam int unsigned CLK_HZ = 50_000_000;

  // Convert milliseconds to clk cycles at CLK_HZ; widened so large ms values do not overflow mid-product
  function automatic int unsigned ms_to_cycles(input int unsigned ms);
    logic [63:0] cyc;
    cyc = 64'(CLK_HZ / 1000) * 64'(ms);
    return 32'(cyc);
  endfunction

  // Larger of two unsigned values, used to size the shared hold/repeat counter
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned LONG_CYCLES_DEF   = ms_to_cycles(1000);
  localparam int unsigned REPEAT_CYCLES_DEF = ms_to_cycles(200);

endpackage : btn_pkg

// File: rtl/btn_level_norm.sv
// Converts the debounced button level to an active-high "pressed" flag and registers it once.
module btn_level_norm
  import btn_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn_level,
  output logic o_act_q
);

  logic w_act;
  logic r_act_q;

  assign w_act = i_btn_level ^ ACTIVE_LOW;

  // Single register stage: the decoder FSM only ever sees the registered activity flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_act_q <= 1'b0;
    end else begin
      r_act_q <= w_act;
    end
  end

  assign o_act_q = r_act_q;

endmodule : btn_level_norm

// File: rtl/btn_event_decoder.sv
// Turns a debounced button level into one-cycle short / long / auto-repeat event pulses.
module btn_event_decoder
  import btn_pkg::*;
#(
  parameter bit          ACTIVE_LOW    = 1'b1,
  parameter int unsigned LONG_CYCLES   = LONG_CYCLES_DEF,
  parameter int unsigned REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic btn_level,
  output logic pressed,
  output logic short_pulse,
  output logic long_pulse,
  output logic repeat_pulse
);

  localparam int unsigned CNT_MAX = max_u(LONG_CYCLES, REPEAT_CYCLES);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  logic             w_act_q;
  btn_state_t       r_state;
  btn_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_long_tc;
  logic             w_rep_tc;
  logic             w_pressed_nxt;
  logic             w_short_nxt;
  logic             w_long_nxt;
  logic             w_repeat_nxt;
  logic             r_pressed;
  logic             r_short;
  logic             r_long;
  logic             r_repeat;

  btn_level_norm #(
    .ACTIVE_LOW (ACTIVE_LOW)
  ) u_norm (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_btn_level (btn_level),
    .o_act_q     (w_act_q)
  );

  assign w_long_tc = (r_cnt == CNT_W'(LONG_CYCLES - 1));
  assign w_rep_tc  = (r_cnt == CNT_W'(REPEAT_CYCLES - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; disable overrides everything and a held button is parked in LOCKOUT
  always_comb begin
    w_state_nxt = r_state;
    if (!enable) begin
      w_state_nxt = w_act_q ? LOCKOUT : IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_act_q) w_state_nxt = PRESSED;
        end
        PRESSED: begin
          if (!w_act_q)      w_state_nxt = IDLE;
          else if (w_long_tc) w_state_nxt = HELD;
        end
        HELD: begin
          if (!w_act_q) w_state_nxt = IDLE;
        end
        LOCKOUT: begin
          if (!w_act_q) w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Output / counter next values; release is checked before terminal counts so it wins
  always_comb begin
    w_cnt_nxt    = '0;
    w_short_nxt  = 1'b0;
    w_long_nxt   = 1'b0;
    w_repeat_nxt = 1'b0;
    if (enable) begin
      case (r_state)
        PRESSED: begin
          if (!w_act_q) begin
            w_short_nxt = 1'b1;
          end else if (w_long_tc) begin
            w_long_nxt = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        HELD: begin
          if (w_act_q) begin
            if (w_rep_tc) begin
              w_repeat_nxt = 1'b1;
            end else begin
              w_cnt_nxt = r_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          w_cnt_nxt = '0;
        end
      endcase
    end
    w_pressed_nxt = (w_state_nxt == PRESSED) || (w_state_nxt == HELD);
  end

  // Counter and registered outputs, updated on the same edge as the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_pressed <= 1'b0;
      r_short   <= 1'b0;
      r_long    <= 1'b0;
      r_repeat  <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_pressed <= w_pressed_nxt;
      r_short   <= w_short_nxt;
      r_long    <= w_long_nxt;
      r_repeat  <= w_repeat_nxt;
    end
  end

  assign pressed      = r_pressed;
  assign short_pulse  = r_short;
  assign long_pulse   = r_long;
  assign repeat_pulse = r_repeat;

endmodule : btn_event_decoder

// File: tb/tb_btn_event_decoder.sv
// Scoreboard bench for btn_event_decoder: expected pulses are queued at stimulus time and matched by a monitor.
module tb_btn_event_decoder;

  localparam int unsigned LONG = 20;
  localparam int unsigned REP  = 5;
  localparam int unsigned K_SHORT  = 1;
  localparam int unsigned K_LONG   = 2;
  localparam int unsigned K_REPEAT = 3;

  typedef struct {
    int unsigned kind;
    int unsigned cyc;
  } exp_t;

  logic clk       = 1'b0;
  logic rst_n     = 1'b0;
  logic enable    = 1'b1;
  logic btn_level = 1'b1;
  logic pressed;
  logic short_pulse;
  logic long_pulse;
  logic repeat_pulse;

  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  exp_t        sb[$];

  int unsigned m_n;
  int unsigned m_k;
  exp_t        m_e;

  btn_event_decoder #(
    .ACTIVE_LOW    (1'b1),
    .LONG_CYCLES   (LONG),
    .REPEAT_CYCLES (REP)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .btn_level    (btn_level),
    .pressed      (pressed),
    .short_pulse  (short_pulse),
    .long_pulse   (long_pulse),
    .repeat_pulse (repeat_pulse)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push(input int unsigned kind, input int unsigned at);
    exp_t e;
    e.kind = kind;
    e.cyc  = at;
    sb.push_back(e);
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int unsigned outs();
    return 32'({pressed, short_pulse, long_pulse, repeat_pulse});
  endfunction

  // Monitor: every pulse must match the head of the scoreboard in kind and cycle
  always @(negedge clk) begin
    if (rst_n) begin
      m_n = 32'(short_pulse) + 32'(long_pulse) + 32'(repeat_pulse);
      if (m_n != 0) begin
        chk("pulse_onehot", m_n, 1);
        m_k = short_pulse ? K_SHORT : (long_pulse ? K_LONG : K_REPEAT);
        if (sb.size() == 0) begin
          chk("spurious_pulse", m_k, 0);
        end else begin
          m_e = sb.pop_front();
          chk("pulse_kind", m_k, m_e.kind);
          chk("pulse_cycle", cyc, m_e.cyc);
        end
      end
    end
  end

  initial begin
    int unsigned c;
    int unsigned c2;

    // 1: reset, then idle with button released
    step(3);
    chk("rst_outs", outs(), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step(1);
      chk("idle_outs", outs(), 0);
    end

    // 2: 10-cycle press -> one short pulse two edges after release
    c = cyc;
    btn_level = 1'b0;
    push(K_SHORT, c + 12);
    step(1);
    chk("press_lat1", 32'(pressed), 0);
    step(1);
    chk("press_lat2", 32'(pressed), 1);
    step(8);
    btn_level = 1'b1;
    step(2);
    chk("short_rel_pressed", 32'(pressed), 0);
    step(10);
    chk("sb_empty_short", sb.size(), 0);

    // 3: long hold -> long at +20 from pressed, repeats every 5; release on repeat terminal count
    c = cyc;
    btn_level = 1'b0;
    push(K_LONG, c + 22);
    push(K_REPEAT, c + 27);
    push(K_REPEAT, c + 32);
    push(K_REPEAT, c + 37);
    step(2);
    chk("hold_pressed_rise", 32'(pressed), 1);
    step(38);
    chk("hold_pressed_mid", 32'(pressed), 1);
    btn_level = 1'b1;
    step(1);
    chk("hold_rel_lat1", 32'(pressed), 1);
    step(1);
    chk("hold_rel_lat2", 32'(pressed), 0);
    step(10);
    chk("sb_empty_hold", sb.size(), 0);

    // 4: release lands on the long terminal count -> short only
    c = cyc;
    btn_level = 1'b0;
    push(K_SHORT, c + 22);
    step(20);
    btn_level = 1'b1;
    step(2);
    chk("boundary_pressed", 32'(pressed), 0);
    step(10);
    chk("sb_empty_boundary", sb.size(), 0);

    // 5: enable dropped mid-hold -> lockout until release, then a fresh short press works
    c = cyc;
    btn_level = 1'b0;
    step(5);
    enable = 1'b0;
    step(3);
    chk("dis_pressed", 32'(pressed), 0);
    step(2);
    enable = 1'b1;
    step(15);
    chk("lockout_pressed", 32'(pressed), 0);
    step(5);
    btn_level = 1'b1;
    step(10);
    chk("sb_empty_lockout", sb.size(), 0);
    c = cyc;
    btn_level = 1'b0;
    push(K_SHORT, c + 10);
    step(8);
    btn_level = 1'b1;
    step(10);
    chk("sb_empty_after_lockout", sb.size(), 0);

    // 6: reset mid-hold -> async clear, then a fresh press counts from zero
    c = cyc;
    btn_level = 1'b0;
    step(12);
    chk("prereset_pressed", 32'(pressed), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_outs", outs(), 0);
    step(3);
    rst_n = 1'b1;
    c2 = cyc;
    push(K_LONG, c2 + 22);
    step(1);
    chk("rerun_lat1", 32'(pressed), 0);
    step(1);
    chk("rerun_lat2", 32'(pressed), 1);
    step(20);
    btn_level = 1'b1;
    step(10);
    chk("sb_empty_reset", sb.size(), 0);
    chk("final_outs", outs(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_btn_event_decoder
